// File: rtl/bus_master_port.sv
// bus_master_port: initiator side of the CPU word-wide memory bus.
// Accepts one read or write request at a time from the core, drives registered
// bus strobes/address/data, holds them through waitrequest stalls, and reports
// completion (cpu_done) or timeout (cpu_done + cpu_error). Exactly one transfer
// is outstanding; a one-cycle strobe-low RECOVER phase separates transfers.
module bus_master_port #(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_writedata,
  input  logic [3:0]  cpu_byteenable,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_error,
  output logic [31:0] cpu_readdata,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_writedata,
  output logic [3:0]  bus_byteenable,
  input  logic        bus_waitrequest,
  input  logic [31:0] bus_readdata
);

  // Stall counter is just wide enough to hold TIMEOUT_CYCLES; at least one bit
  // so a disabled timeout still yields a legal vector.
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  // The abort fires on the stalled edge that would bring the count up to
  // TIMEOUT_CYCLES, i.e. when the count already equals TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES < 1) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  // Word-align mask applied to the incoming byte address.
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             timeout_hit;
  logic             cpu_request;

  assign cpu_request = cpu_read | cpu_write;

  // Abort condition: only meaningful while stalled in ACCESS; completion
  // (waitrequest low) is checked first in the FSM so it wins on a tie.
  assign timeout_hit = TIMEOUT_EN && (stall_cnt_reg == CNT_LAST);

  // The core sees the port busy for the whole transfer including RECOVER.
  assign cpu_busy = (state_reg != ST_IDLE);

  // Transfer FSM with all bus and core-side outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      stall_cnt_reg  <= '0;
      cpu_done       <= 1'b0;
      cpu_error      <= 1'b0;
      cpu_readdata   <= '0;
      bus_address    <= '0;
      bus_read       <= 1'b0;
      bus_write      <= 1'b0;
      bus_writedata  <= '0;
      bus_byteenable <= '0;
    end else begin
      // Status pulses last exactly one cycle (the RECOVER cycle).
      cpu_done  <= 1'b0;
      cpu_error <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (cpu_request) begin
            bus_address    <= cpu_address & WORD_MASK;
            bus_writedata  <= cpu_writedata;
            bus_byteenable <= cpu_byteenable;
            // Write has priority; exactly one strobe is raised.
            bus_write      <= cpu_write;
            bus_read       <= ~cpu_write;
            stall_cnt_reg  <= '0;
            state_reg      <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          if (!bus_waitrequest) begin
            if (bus_read) begin
              cpu_readdata <= bus_readdata;
            end
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            cpu_done  <= 1'b1;
            state_reg <= ST_RECOVER;
          end else if (timeout_hit) begin
            // Abort: readdata keeps its previous value.
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            cpu_done  <= 1'b1;
            cpu_error <= 1'b1;
            state_reg <= ST_RECOVER;
          end else if (stall_cnt_reg != CNT_MAX) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
          end
        end

        ST_RECOVER: begin
          // Guaranteed strobe-low cycle before the next request is sampled.
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
          bus_read  <= 1'b0;
          bus_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// Directed testbench for bus_master_port. A main instance (TIMEOUT_CYCLES=8)
// is paired with a second instance (TIMEOUT_CYCLES=4) sharing the CPU-side and
// waitrequest stimulus, used for the timeout scenarios.
module tb_bus_master_port;

  logic        clk;
  logic        reset_n;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_address;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic        bus_waitrequest;

  logic        cpu_busy, cpu_done, cpu_error;
  logic [31:0] cpu_readdata, bus_address, bus_writedata, bus_readdata;
  logic        bus_read, bus_write;
  logic [3:0]  bus_byteenable;

  logic        cpu_busy_t, cpu_done_t, cpu_error_t;
  logic [31:0] cpu_readdata_t, bus_address_t, bus_writedata_t, bus_readdata_t;
  logic        bus_read_t, bus_write_t;
  logic [3:0]  bus_byteenable_t;

  int checks;
  int failures;

  // Simple word memory shared by both instances; only the main instance writes.
  logic [31:0] mem [0:15];
  logic        load_en;
  logic [3:0]  load_idx;
  logic [31:0] load_data;

  assign bus_readdata   = mem[bus_address[5:2]];
  assign bus_readdata_t = mem[bus_address_t[5:2]];

  always @(posedge clk) begin
    if (load_en) begin
      mem[load_idx] <= load_data;
    end else if (bus_write && !bus_waitrequest) begin
      for (int b = 0; b < 4; b++) begin
        if (bus_byteenable[b]) mem[bus_address[5:2]][8*b +: 8] <= bus_writedata[8*b +: 8];
      end
    end
  end

  bus_master_port #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_error(cpu_error),
    .cpu_readdata(cpu_readdata), .bus_address(bus_address),
    .bus_read(bus_read), .bus_write(bus_write), .bus_writedata(bus_writedata),
    .bus_byteenable(bus_byteenable), .bus_waitrequest(bus_waitrequest),
    .bus_readdata(bus_readdata)
  );

  bus_master_port #(.TIMEOUT_CYCLES(4)) dut_t (
    .clk(clk), .reset_n(reset_n),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_busy(cpu_busy_t), .cpu_done(cpu_done_t), .cpu_error(cpu_error_t),
    .cpu_readdata(cpu_readdata_t), .bus_address(bus_address_t),
    .bus_read(bus_read_t), .bus_write(bus_write_t), .bus_writedata(bus_writedata_t),
    .bus_byteenable(bus_byteenable_t), .bus_waitrequest(bus_waitrequest),
    .bus_readdata(bus_readdata_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    reset_n = 1'b0;
    cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_address = '0; cpu_writedata = '0; cpu_byteenable = '0;
    bus_waitrequest = 1'b0;
    load_en = 1'b0; load_idx = '0; load_data = '0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      load_idx  = i[3:0];
      load_data = (i == 4) ? 32'hDEADBEEF : ((i == 5) ? 32'hCAFEF00D : 32'h0);
      load_en   = 1'b1;
      @(negedge clk);
    end
    load_en = 1'b0;
    checks++;
    if ({cpu_busy, cpu_done, cpu_error, bus_read, bus_write} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000", {cpu_busy, cpu_done, cpu_error, bus_read, bus_write});
    end
    checks++;
    if ({cpu_readdata, bus_address, bus_writedata, bus_byteenable} !== 100'h0) begin
      failures++;
      $display("FAIL reset_data: got rd=%h addr=%h wd=%h be=%h expected all zero",
               cpu_readdata, bus_address, bus_writedata, bus_byteenable);
    end
    checks++;
    if ({cpu_busy_t, cpu_done_t, cpu_error_t, bus_read_t, bus_write_t, cpu_readdata_t, bus_address_t} !== 69'h0) begin
      failures++;
      $display("FAIL reset_t: got ctrl=%b rd=%h addr=%h expected all zero",
               {cpu_busy_t, cpu_done_t, cpu_error_t, bus_read_t, bus_write_t}, cpu_readdata_t, bus_address_t);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cpu_busy, bus_read, bus_write} !== 3'b000) begin
      failures++;
      $display("FAIL reset_release_idle: got %b expected 000", {cpu_busy, bus_read, bus_write});
    end
    $display("txn reset: outputs idle after reset");
  endtask

  task automatic test_zero_stall_read;
    @(negedge clk);
    cpu_read = 1'b1; cpu_address = 32'h10; bus_waitrequest = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_read, bus_write, cpu_busy, cpu_done} !== 4'b1010 || bus_address !== 32'h10) begin
      failures++;
      $display("FAIL zs_read_strobe: got rd/wr/busy/done=%b addr=%h expected 1010 addr=00000010",
               {bus_read, bus_write, cpu_busy, cpu_done}, bus_address);
    end
    @(negedge clk);
    checks++;
    if ({bus_read, bus_write, cpu_done, cpu_error, cpu_busy} !== 5'b00101) begin
      failures++;
      $display("FAIL zs_read_done: got rd/wr/done/err/busy=%b expected 00101",
               {bus_read, bus_write, cpu_done, cpu_error, cpu_busy});
    end
    checks++;
    if (cpu_readdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL zs_read_data: got %h expected deadbeef", cpu_readdata);
    end
    cpu_read = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_read, cpu_done, cpu_busy} !== 3'b000) begin
      failures++;
      $display("FAIL zs_read_after: got rd/done/busy=%b expected 000", {bus_read, cpu_done, cpu_busy});
    end
    $display("txn zero_stall_read addr=00000010 data=%h", cpu_readdata);
  endtask

  task automatic test_stalled_write;
    int bad;
    bad = 0;
    @(negedge clk);
    cpu_write = 1'b1; cpu_address = 32'h23; cpu_writedata = 32'h12345678;
    cpu_byteenable = 4'b0101; bus_waitrequest = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if ({bus_write, bus_read, cpu_done} !== 3'b100 || bus_address !== 32'h20 ||
          bus_writedata !== 32'h12345678 || bus_byteenable !== 4'b0101) begin
        bad++;
        $display("FAIL sw_hold_cycle%0d: got wr/rd/done=%b addr=%h wd=%h be=%b expected 100 00000020 12345678 0101",
                 i, {bus_write, bus_read, cpu_done}, bus_address, bus_writedata, bus_byteenable);
      end
      bus_waitrequest = (i < 5);
    end
    checks++;
    if (bad != 0) failures++;
    @(negedge clk);
    checks++;
    if ({bus_write, cpu_done, cpu_error} !== 3'b010) begin
      failures++;
      $display("FAIL sw_done: got wr/done/err=%b expected 010", {bus_write, cpu_done, cpu_error});
    end
    cpu_write = 1'b0;
    @(negedge clk);
    cpu_read = 1'b1; cpu_address = 32'h20;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cpu_done !== 1'b1 || cpu_readdata !== 32'h00340078) begin
      failures++;
      $display("FAIL sw_readback: got done=%b data=%h expected 1 00340078", cpu_done, cpu_readdata);
    end
    cpu_read = 1'b0;
    @(negedge clk);
    $display("txn stalled_write addr=00000023 be=0101 readback=%h", cpu_readdata);
  endtask

  task automatic test_timeout;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cpu_read = 1'b1; cpu_address = 32'h20; bus_waitrequest = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cpu_done_t !== 1'b1 || cpu_readdata_t !== 32'h00340078) begin
      failures++;
      $display("FAIL to_preload: got done=%b data=%h expected 1 00340078", cpu_done_t, cpu_readdata_t);
    end
    cpu_read = 1'b0;
    @(negedge clk);
    cpu_read = 1'b1; cpu_address = 32'h10; bus_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bus_read_t, cpu_done_t, cpu_error_t} !== 3'b100 || bus_address_t !== 32'h10) begin
        failures++;
        $display("FAIL to_stall_cycle%0d: got rd/done/err=%b addr=%h expected 100 00000010",
                 i, {bus_read_t, cpu_done_t, cpu_error_t}, bus_address_t);
      end
    end
    @(negedge clk);
    checks++;
    if ({bus_read_t, bus_write_t, cpu_done_t, cpu_error_t, cpu_busy_t} !== 5'b00111) begin
      failures++;
      $display("FAIL to_abort: got rd/wr/done/err/busy=%b expected 00111",
               {bus_read_t, bus_write_t, cpu_done_t, cpu_error_t, cpu_busy_t});
    end
    checks++;
    if (cpu_readdata_t !== 32'h00340078) begin
      failures++;
      $display("FAIL to_readdata_kept: got %h expected 00340078", cpu_readdata_t);
    end
    cpu_read = 1'b0; bus_waitrequest = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_done_t, cpu_error_t} !== 2'b00) begin
      failures++;
      $display("FAIL to_pulse_width: got done/err=%b expected 00", {cpu_done_t, cpu_error_t});
    end
    checks++;
    if ({cpu_done, cpu_error} !== 2'b10 || cpu_readdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL to_long_limit: got done/err=%b data=%h expected 10 deadbeef",
               {cpu_done, cpu_error}, cpu_readdata);
    end
    @(negedge clk);
    @(negedge clk);
    $display("txn timeout limit=4 done=1 error=1 readdata kept");
  endtask

  task automatic test_timeout_boundary;
    @(negedge clk);
    cpu_read = 1'b1; cpu_address = 32'h14; bus_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus_read_t !== 1'b1) begin
        failures++;
        $display("FAIL tb_hold_cycle%0d: got rd=%b expected 1", i, bus_read_t);
      end
      bus_waitrequest = (i < 3);
    end
    @(negedge clk);
    checks++;
    if ({cpu_done_t, cpu_error_t} !== 2'b10 || cpu_readdata_t !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL tb_complete_wins: got done/err=%b data=%h expected 10 cafef00d",
               {cpu_done_t, cpu_error_t}, cpu_readdata_t);
    end
    cpu_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("txn timeout_boundary completion on limit edge data=%h", cpu_readdata_t);
  endtask

  task automatic test_back_to_back;
    int pulses, dones, low_run, gap_bad, width_bad, overlap;
    logic prev_read;
    pulses = 0; dones = 0; low_run = 0; gap_bad = 0; width_bad = 0; overlap = 0;
    prev_read = 1'b0;
    @(negedge clk);
    cpu_read = 1'b1; cpu_address = 32'h10; bus_waitrequest = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_read && bus_write) overlap++;
      if (bus_read) begin
        if (!prev_read) begin
          pulses++;
          if (pulses > 1 && low_run < 2) gap_bad++;
        end else begin
          width_bad++;
        end
        low_run = 0;
      end else begin
        low_run++;
      end
      if (cpu_done) dones++;
      prev_read = bus_read;
    end
    cpu_read = 1'b0;
    @(negedge clk);
    checks++;
    if (pulses != 4 || dones != 4) begin
      failures++;
      $display("FAIL b2b_counts: got pulses=%0d dones=%0d expected 4 4", pulses, dones);
    end
    checks++;
    if (gap_bad != 0 || width_bad != 0 || overlap != 0) begin
      failures++;
      $display("FAIL b2b_spacing: got short_gaps=%0d long_pulses=%0d overlaps=%0d expected 0 0 0",
               gap_bad, width_bad, overlap);
    end
    checks++;
    if (cpu_busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: got busy=%b expected 0", cpu_busy);
    end
    $display("txn back_to_back reads pulses=%0d dones=%0d", pulses, dones);
  endtask

  task automatic test_simultaneous;
    @(negedge clk);
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = 32'h30;
    cpu_writedata = 32'hA5A5A5A5; cpu_byteenable = 4'b1111; bus_waitrequest = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_write, bus_read} !== 2'b10 || bus_address !== 32'h30) begin
      failures++;
      $display("FAIL sim_priority: got wr/rd=%b addr=%h expected 10 00000030", {bus_write, bus_read}, bus_address);
    end
    @(negedge clk);
    checks++;
    if ({cpu_done, bus_read, bus_write} !== 3'b100 || cpu_readdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL sim_done: got done/rd/wr=%b data=%h expected 100 deadbeef",
               {cpu_done, bus_read, bus_write}, cpu_readdata);
    end
    cpu_read = 1'b0; cpu_write = 1'b0;
    @(negedge clk);
    $display("txn simultaneous read+write -> write addr=00000030");
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    cpu_read = 1'b1; cpu_address = 32'h10; bus_waitrequest = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_read !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: got rd=%b expected 1", bus_read);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus_read, bus_write, cpu_busy, cpu_done, cpu_error} !== 5'b0 ||
        cpu_readdata !== 32'h0 || bus_address !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_async: got ctrl=%b rd=%h addr=%h expected 00000 0 0",
               {bus_read, bus_write, cpu_busy, cpu_done, cpu_error}, cpu_readdata, bus_address);
    end
    cpu_read = 1'b0; bus_waitrequest = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (cpu_done !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_no_done%0d: got done=%b expected 0", i, cpu_done);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
    cpu_read = 1'b1; cpu_address = 32'h30;
    @(negedge clk);
    checks++;
    if (bus_read !== 1'b1 || bus_address !== 32'h30) begin
      failures++;
      $display("FAIL rst_mid_next_strobe: got rd=%b addr=%h expected 1 00000030", bus_read, bus_address);
    end
    @(negedge clk);
    checks++;
    if ({cpu_done, cpu_error} !== 2'b10 || cpu_readdata !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL rst_mid_next_done: got done/err=%b data=%h expected 10 a5a5a5a5",
               {cpu_done, cpu_error}, cpu_readdata);
    end
    cpu_read = 1'b0;
    @(negedge clk);
    $display("txn reset_mid_access then read addr=00000030 data=%h", cpu_readdata);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_zero_stall_read();
    test_stalled_write();
    test_timeout();
    test_timeout_boundary();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_master_port.md
# bus_master_port

Initiator side of the CPU's word-wide memory bus. It accepts one read or write request at a time from the CPU core and drives the bus address, read, write, writedata and byteenable lines. It holds those lines stable while the responder asserts waitrequest, captures readdata on completion, and reports done or error back to the core. It sits between the CPU datapath and the bus memory / future peripherals, with exactly one transfer outstanding.

## Interface
Parameters:
- TIMEOUT_CYCLES, 32: number of consecutive waitrequest-high ACCESS cycles before the transfer is aborted; 0 disables the timeout.

Ports (reset is asynchronous, active-low; single clock domain):
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- cpu_read  in  1  request a read; level, sampled only in IDLE
- cpu_write  in  1  request a write; level, sampled only in IDLE; wins over cpu_read if both are high
- cpu_address  in  32  byte address of the request
- cpu_writedata  in  32  write data
- cpu_byteenable  in  4  lane enables; bit n enables byte lane n
- cpu_busy  out  1  high in ACCESS and RECOVER
- cpu_done  out  1  one-cycle pulse when the transfer finishes or is aborted
- cpu_error  out  1  one-cycle pulse, coincident with cpu_done, on timeout
- cpu_readdata  out  32  last successfully read word; held until the next successful read
- bus_address  out  32  cpu_address with bits [1:0] forced to 0
- bus_read  out  1  bus read strobe
- bus_write  out  1  bus write strobe
- bus_writedata  out  32  write data
- bus_byteenable  out  4  lane enables
- bus_waitrequest  in  1  responder stall
- bus_readdata  in  32  responder read data; valid in the cycle waitrequest is low

## Operation
- State machine: IDLE, ACCESS, RECOVER. All bus outputs are registered.
- IDLE:
  - On a clock edge with cpu_write or cpu_read high, latch address (bits [1:0] cleared), writedata and byteenable into the bus registers.
  - Set exactly one of bus_write or bus_read; write takes priority.
  - Clear the stall counter and go to ACCESS.
- ACCESS:
  - Bus outputs are held constant.
  - On an edge with bus_waitrequest low, the transfer completes:
    - for a read, cpu_readdata <= bus_readdata;
    - clear bus_read and bus_write;
    - set cpu_done for the next cycle;
    - go to RECOVER.
  - On an edge with bus_waitrequest high, increment the stall counter.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, abort:
    - clear the strobes;
    - set cpu_done and cpu_error for the next cycle;
    - cpu_readdata is unchanged;
    - go to RECOVER.
- RECOVER:
  - Exactly one cycle with both strobes low; cpu_done (and cpu_error on abort) is high in this cycle.
  - Then go to IDLE.
  - This guarantees the responder sees a strobe-low cycle between transfers.
- Stall counter:
  - Width is clog2(TIMEOUT_CYCLES+1), minimum 1 bit.
  - Saturates; it never wraps.
- CPU inputs are ignored outside IDLE. The core must hold its request until cpu_done; a still-high request is re-accepted in IDLE as a new transfer.
- bus_read and bus_write are never high together.

## Timing
- Reset:
  - All outputs are 0 and the state is IDLE.
  - The reset takes effect immediately and asynchronously, including mid-ACCESS, dropping the bus strobes without completion.
  - No cpu_done is generated for a transfer aborted by reset.
- Request sampled at edge N: strobe high from cycle N+1.
- Zero-stall responder (waitrequest low in the first ACCESS cycle):
  - completion at edge N+1;
  - cpu_done high in cycle N+2;
  - next request can be sampled at edge N+3.
- Each waitrequest-high ACCESS cycle adds one cycle of latency.
- Minimum strobe-to-strobe spacing is 2 low cycles: RECOVER plus one IDLE cycle.
- Timeout: with the strobe rising in cycle N+1 and waitrequest stuck high, abort occurs at edge N+TIMEOUT_CYCLES. cpu_done and cpu_error are high in cycle N+TIMEOUT_CYCLES+1.
- If waitrequest falls on the same edge the counter would reach the limit, completion wins and there is no error.

## Test plan
- Zero-stall read: memory returns 0xDEADBEEF at address 0x00000010 with waitrequest low → bus_read high for exactly 1 cycle, cpu_readdata = 0xDEADBEEF, cpu_done pulses once in the following cycle, cpu_error = 0.
- Stalled write: write 0x12345678 with byteenable 0b0101 to address 0x00000023, waitrequest high for 5 cycles → bus_address = 0x00000020; address/data/byteenable stable for all 6 ACCESS cycles; write completes on the 6th; readback 0x00340078 over zeroed memory.
- Timeout: TIMEOUT_CYCLES=4, waitrequest stuck high → strobe drops after 4 cycles; cpu_done and cpu_error pulse together; cpu_readdata keeps its previous value.
- Back-to-back: cpu_read held high continuously → a strobe-low gap of ≥2 cycles between successive bus_read pulses, and one cpu_done per transfer.
- Simultaneous cpu_read and cpu_write → bus_write only; bus_read never high.
- Reset mid-ACCESS: assert reset_n=0 during a stalled read → bus_read drops in the same cycle without a clock, no cpu_done pulse, all outputs 0; after release, the next request proceeds normally.
